// File: rtl/prio_encoder8to3_q.sv
// Registered 8-to-3 priority encoder that latches active-low requests into a sticky
// pending register and presents one index at a time over a valid/ready handshake.
module prio_encoder8to3_q #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_n,
  output logic [2:0] code,
  output logic       valid,
  input  logic       ready,
  output logic [7:0] pending,
  output logic       multi
);

  logic [7:0] pending_q, pending_d;
  logic       valid_q, valid_d;
  logic [2:0] code_q, code_d;

  logic       acc;
  logic [7:0] clr_vec;
  logic [7:0] cand_vec;

  // The winner is the last hit in scan order, so scan from lowest to highest priority.
  function automatic logic [2:0] prio_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (LSB_FIRST) begin
        if (v[7-i]) idx = 3'(7 - i);
      end else begin
        if (v[i]) idx = 3'(i);
      end
    end
    return idx;
  endfunction

  always_comb begin
    acc       = valid_q & ready;
    clr_vec   = acc ? (8'd1 << code_q) : 8'h00;
    // A same-cycle set of the accepted bit re-pends it.
    pending_d = (pending_q & ~clr_vec) | ~req_n;
    // Selection looks at the registered pending value only, minus the bit just taken.
    cand_vec  = pending_q & ~clr_vec;
    valid_d   = valid_q;
    code_d    = code_q;
    if (!(valid_q && !ready)) begin
      if (cand_vec != 8'h00) begin
        valid_d = 1'b1;
        code_d  = prio_idx(cand_vec);
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 8'h00;
      valid_q   <= 1'b0;
      code_q    <= 3'd0;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
    end
  end

  assign code    = code_q;
  assign valid   = valid_q;
  assign pending = pending_q;
  assign multi   = (pending_q & (pending_q - 8'd1)) != 8'h00;

endmodule

// File: tb/tb_prio_encoder8to3_q.sv
// Bench for prio_encoder8to3_q: one LSB-first and one MSB-first instance on shared stimulus.
module tb_prio_encoder8to3_q;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req_n = 8'hFF;
  logic       ready = 1'b0;

  logic [2:0] code_a, code_b;
  logic       valid_a, valid_b, multi_a, multi_b;
  logic [7:0] pending_a, pending_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  prio_encoder8to3_q #(.LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .req_n(req_n), .code(code_a), .valid(valid_a),
    .ready(ready), .pending(pending_a), .multi(multi_a)
  );

  prio_encoder8to3_q #(.LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .req_n(req_n), .code(code_b), .valid(valid_b),
    .ready(ready), .pending(pending_b), .multi(multi_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: index 0 = LSB-first instance, index 1 = MSB-first instance.
  logic [7:0] m_pend [2] = '{8'h00, 8'h00};
  logic       m_valid[2] = '{1'b0, 1'b0};
  logic [2:0] m_code [2] = '{3'd0, 3'd0};

  function automatic logic [2:0] pick(input logic [7:0] v, input bit lsb_first);
    if (lsb_first) begin
      for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--) if (v[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [7:0] clr, cand;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_pend[k]  <= 8'h00;
        m_valid[k] <= 1'b0;
        m_code[k]  <= 3'd0;
      end else begin
        clr = (m_valid[k] && ready) ? (8'd1 << m_code[k]) : 8'h00;
        m_pend[k] <= (m_pend[k] & ~clr) | ~req_n;
        if (!(m_valid[k] && !ready)) begin
          cand = m_pend[k] & ~clr;
          if (cand != 8'h00) begin
            m_valid[k] <= 1'b1;
            m_code[k]  <= pick(cand, (k == 0));
          end else begin
            m_valid[k] <= 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_a", {valid_a, code_a, pending_a, multi_a},
        {m_valid[0], m_code[0], m_pend[0], ($countones(m_pend[0]) >= 2)});
    chk("model_b", {valid_b, code_b, pending_b, multi_b},
        {m_valid[1], m_code[1], m_pend[1], ($countones(m_pend[1]) >= 2)});
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // 1. reset and idle
    repeat (2) tick();
    chk("rst_a", {valid_a, code_a, pending_a, multi_a}, 13'h0);
    chk("rst_b", {valid_b, code_b, pending_b, multi_b}, 13'h0);
    rst = 1'b0;
    repeat (5) tick();
    chk("idle_a", {valid_a, pending_a}, 9'h0);

    // 2. single request on bit 2
    req_n = 8'hFB; ready = 1'b1;
    tick();
    chk("single_pend1", pending_a, 8'h04);
    chk("single_vld1", valid_a, 1'b0);
    req_n = 8'hFF;
    tick();
    chk("single_vld2", valid_a, 1'b1);
    chk("single_code2", code_a, 3'd2);
    tick();
    chk("single_vld3", valid_a, 1'b0);
    chk("single_pend3", pending_a, 8'h00);

    // 3/4. bits 0,2,5,7 with backpressure, then drain
    ready = 1'b0; req_n = 8'h5A;
    tick();
    chk("multi_pend", pending_a, 8'hA5);
    chk("multi_flag", multi_a, 1'b1);
    req_n = 8'hFF;
    tick();
    chk("bp_code_a", {valid_a, code_a}, {1'b1, 3'd0});
    chk("bp_code_b", {valid_b, code_b}, {1'b1, 3'd7});
    repeat (3) tick();
    chk("bp_hold_a", {valid_a, code_a, pending_a}, {1'b1, 3'd0, 8'hA5});
    chk("bp_hold_b", {valid_b, code_b}, {1'b1, 3'd7});
    ready = 1'b1;
    tick();
    chk("drain1_a", {code_a, pending_a}, {3'd2, 8'hA4});
    chk("drain1_b", code_b, 3'd5);
    tick();
    chk("drain2_a", {code_a, pending_a}, {3'd5, 8'hA0});
    chk("drain2_b", code_b, 3'd2);
    tick();
    chk("drain3_a", {code_a, pending_a, multi_a}, {3'd7, 8'h80, 1'b0});
    chk("drain3_b", {code_b, pending_b}, {3'd0, 8'h01});
    tick();
    chk("drain4_a", {valid_a, pending_a}, 9'h0);
    chk("drain4_b", {valid_b, pending_b}, 9'h0);

    // 5. bit 3 re-requested in the cycle it is accepted
    ready = 1'b0; req_n = 8'hB7;
    tick();
    req_n = 8'hFF;
    tick();
    chk("coll_pres", {valid_a, code_a}, {1'b1, 3'd3});
    ready = 1'b1; req_n = 8'hF7;
    tick();
    chk("coll_keep", {valid_a, code_a, pending_a}, {1'b1, 3'd6, 8'h48});
    req_n = 8'hFF;
    tick();
    chk("coll_repres", {valid_a, code_a, pending_a[3]}, {1'b1, 3'd3, 1'b1});
    tick();
    chk("coll_done", {valid_a, pending_a}, 9'h0);

    // 6. async reset mid-handshake
    ready = 1'b0; req_n = 8'h5A;
    tick();
    req_n = 8'hFF;
    tick();
    chk("pre_rst", {valid_a, pending_a}, {1'b1, 8'hA5});
    #2 rst = 1'b1;
    #1;
    chk("async_rst_a", {valid_a, code_a, pending_a}, 12'h0);
    chk("async_rst_b", {valid_b, code_b, pending_b}, 12'h0);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("post_rst", {valid_a, pending_a, valid_b, pending_b}, 18'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
